// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, FSM encoding and sample type for the NN sample sequencer
package nn_pkg;

    localparam int NN_XW    = 9;
    localparam int NN_YW    = 17;
    localparam int NN_NFEAT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        EMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [NN_XW-1:0] x3;
        logic signed [NN_XW-1:0] x2;
        logic signed [NN_XW-1:0] x1;
        logic signed [NN_XW-1:0] x0;
    } sample_t;

endpackage

// File: rtl/nn_sample_fifo.sv
// rtl/nn_sample_fifo.sv - synchronous sample FIFO, no push-to-pop bypass
// Head is read combinationally from storage; a pop advances it on the edge.
module nn_sample_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nn_sample_sequencer.sv
// rtl/nn_sample_sequencer.sv - buffers samples, holds each on the core inputs, emits captured results
// One sample in flight: IDLE pops, HOLD waits for the core to settle, EMIT waits for the consumer.
module nn_sample_sequencer
    import nn_pkg::*;
#(
    parameter int XW          = NN_XW,
    parameter int YW          = NN_YW,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [XW-1:0] s_x0,
    input  logic signed [XW-1:0] s_x1,
    input  logic signed [XW-1:0] s_x2,
    input  logic signed [XW-1:0] s_x3,
    output logic signed [XW-1:0] x0,
    output logic signed [XW-1:0] x1,
    output logic signed [XW-1:0] x2,
    output logic signed [XW-1:0] x3,
    input  logic signed [YW-1:0] y0,
    input  logic signed [YW-1:0] y1,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [YW-1:0] m_y0,
    output logic signed [YW-1:0] m_y1,
    output logic                 m_class,
    output logic                 busy
);

    localparam int SW = NN_NFEAT * XW;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [SW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          load;
    logic          capture;

    nn_sample_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (s_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   ({s_x3, s_x2, s_x1, s_x0}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_ready = !fifo_full;
    assign busy    = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        load     = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                // Returning to IDLE first leaves one bubble before the next pop.
                if (m_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            x3      <= '0;
            m_valid <= 1'b0;
            m_y0    <= '0;
            m_y1    <= '0;
            m_class <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                x0  <= $signed(head[XW-1:0]);
                x1  <= $signed(head[2*XW-1:XW]);
                x2  <= $signed(head[3*XW-1:2*XW]);
                x3  <= $signed(head[4*XW-1:3*XW]);
                cnt <= CNT_LOAD;
            end else if (state == HOLD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                m_y0    <= y0;
                m_y1    <= y1;
                m_class <= (y1 > y0);
                m_valid <= 1'b1;
            end else if (state == EMIT && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
